// File: rtl/apb_master_bridge.sv
// Command/response to APB master bridge: IDLE -> SETUP -> ACCESS, one outstanding transfer.
// Optional ACCESS-phase watchdog enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_bridge #(
    parameter int ADDR_W         = 7,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr,
    output logic              timeout
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t            state_reg, state_next;
    logic              accept, xfer_done, xfer_abort, tmo_hit, rd_ok;
    logic              pwrite_reg, rsp_valid_reg, rsp_err_reg, timeout_reg;
    logic [ADDR_W-1:0] paddr_reg;
    logic [DATA_W-1:0] pwdata_reg, rsp_rdata_reg, rsp_rdata_next;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        xfer_done  = 1'b0;
        xfer_abort = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid && !rsp_valid_reg) begin
                    accept     = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: state_next = ACCESS;
            ACCESS: begin
                if (pready) begin
                    xfer_done  = 1'b1;
                    state_next = IDLE;
                end else if (tmo_hit) begin
                    xfer_abort = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] tmo_cnt_reg;

    // Counts stalled ACCESS cycles; hit means this is the last allowed one.
    assign tmo_hit = (tmo_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn)                          tmo_cnt_reg <= '0;
        else if (state_reg == SETUP)           tmo_cnt_reg <= '0;
        else if (state_reg == ACCESS && !pready && !tmo_hit)
                                               tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign tmo_hit            = 1'b0;
`endif

    // Read data is only forwarded for an error-free read completion.
    assign rd_ok = xfer_done && !pwrite_reg && !pslverr;

    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_rdata
            assign rsp_rdata_next[gi] = prdata[gi] & rd_ok;
        end
    endgenerate

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            pwrite_reg    <= 1'b0;
            paddr_reg     <= '0;
            pwdata_reg    <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= '0;
            timeout_reg   <= 1'b0;
        end else begin
            timeout_reg <= xfer_abort;
            if (accept) begin
                pwrite_reg <= req_write;
                paddr_reg  <= req_addr;
                pwdata_reg <= req_write ? req_wdata : '0;
            end
            if (xfer_done || xfer_abort) begin
                rsp_valid_reg <= 1'b1;
                rsp_err_reg   <= xfer_abort | pslverr;
                rsp_rdata_reg <= rsp_rdata_next;
            end else if (rsp_valid_reg && rsp_ready) begin
                rsp_valid_reg <= 1'b0;
                rsp_err_reg   <= 1'b0;
                rsp_rdata_reg <= '0;
            end
        end
    end

    assign req_ready = (state_reg == IDLE) && !rsp_valid_reg;
    assign psel      = (state_reg != IDLE);
    assign penable   = (state_reg == ACCESS);
    assign pwrite    = pwrite_reg;
    assign paddr     = paddr_reg;
    assign pwdata    = pwdata_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_err   = rsp_err_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign timeout   = timeout_reg;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: table of transfers plus hand-written corner sequences.
// Timeout checks follow APB_MASTER_TIMEOUT_EN.
module tb_apb_master_bridge;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        req_valid, req_ready, req_write;
    logic [6:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        psel, penable, pwrite;
    logic [6:0]  paddr;
    logic [31:0] pwdata, prdata;
    logic        pready, pslverr, timeout;

    int pass_cnt = 0;
    int total_cnt = 0;

    apb_master_bridge #(.ADDR_W(7), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
        .pclk(pclk), .presetn(presetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr), .timeout(timeout)
    );

    always #5 pclk = ~pclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        write;
        logic [6:0]  addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] rdata_in;
        logic        slverr;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [31:0] exp_wd;
        exp_wd = v.write ? v.wdata : 32'h0;
        chk("idle_req_ready", {31'b0, req_ready}, 32'h1);
        req_valid = 1'b1; req_write = v.write; req_addr = v.addr; req_wdata = v.wdata;
        step();
        chk("setup_psel", {30'b0, psel, penable}, 32'h2);
        chk("setup_paddr", {25'b0, paddr}, {25'b0, v.addr});
        chk("setup_pwrite", {31'b0, pwrite}, {31'b0, v.write});
        chk("setup_pwdata", pwdata, exp_wd);
        req_valid = 1'b0; req_wdata = 32'h0BAD_0BAD;
        // pready during SETUP must be ignored
        pready = 1'b1; pslverr = 1'b1; prdata = 32'h1111_2222;
        step();
        chk("access_psel", {30'b0, psel, penable}, 32'h3);
        pready = 1'b0; pslverr = 1'b0;
        for (int w = 0; w < v.waits; w++) begin
            step();
            chk("wait_psel", {30'b0, psel, penable}, 32'h3);
            chk("wait_paddr", {25'b0, paddr}, {25'b0, v.addr});
            chk("wait_pwdata", pwdata, exp_wd);
        end
        pready = 1'b1; pslverr = v.slverr; prdata = v.rdata_in;
        step();
        pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
        chk("done_psel", {30'b0, psel, penable}, 32'h0);
        chk("done_rsp_valid", {31'b0, rsp_valid}, 32'h1);
        chk("done_rsp_err", {31'b0, rsp_err}, {31'b0, v.exp_err});
        chk("done_rsp_rdata", rsp_rdata, v.exp_rdata);
        chk("done_timeout", {31'b0, timeout}, 32'h0);
        chk("done_req_ready", {31'b0, req_ready}, 32'h0);
        $display("txn %0d: %s addr=0x%02h waits=%0d rdata=0x%08h err=%0b", idx,
                 v.write ? "WR" : "RD", v.addr, v.waits, rsp_rdata, rsp_err);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("consumed_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("consumed_req_ready", {31'b0, req_ready}, 32'h1);
    endtask

    initial begin
        logic [31:0] held;
        vecs[0] = '{1'b1, 7'h12, 32'hDEADBEEF, 0, 32'hCAFEF00D, 1'b0, 32'h0,        1'b0};
        vecs[1] = '{1'b0, 7'h04, 32'h0,        3, 32'hA5A5A5A5, 1'b0, 32'hA5A5A5A5, 1'b0};
        vecs[2] = '{1'b0, 7'h7F, 32'h0,        0, 32'h12345678, 1'b1, 32'h0,        1'b1};
        vecs[3] = '{1'b1, 7'h00, 32'h00000001, 1, 32'h87654321, 1'b1, 32'h0,        1'b1};
        vecs[4] = '{1'b0, 7'h55, 32'h0,        1, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1'b0};
        vecs[5] = '{1'b1, 7'h7F, 32'h0,        2, 32'h5A5A5A5A, 1'b0, 32'h0,        1'b0};

        presetn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
        repeat (3) step();
        chk("reset_ctrl", {26'b0, psel, penable, pwrite, rsp_valid, rsp_err, timeout}, 32'h0);
        chk("reset_paddr", {25'b0, paddr}, 32'h0);
        chk("reset_pwdata", pwdata, 32'h0);
        chk("reset_rdata", rsp_rdata, 32'h0);
        @(negedge pclk);
        presetn = 1'b1;
        step();
        chk("post_reset_req_ready", {31'b0, req_ready}, 32'h1);

        // Minimum latency: accept N, SETUP N+1, ACCESS N+2, rsp_valid N+3
        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Backpressure: response held while rsp_ready low and a new request waits
        req_valid = 1'b1; req_write = 1'b0; req_addr = 7'h21;
        step(); step();
        pready = 1'b1; pslverr = 1'b0; prdata = 32'h0F0F_1234;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 7'h33; req_wdata = 32'h7777_8888;
        step();
        pready = 1'b0; prdata = 32'h0;
        held = rsp_rdata;
        chk("bp_first_rdata", rsp_rdata, 32'h0F0F_1234);
        for (int c = 0; c < 5; c++) begin
            step();
            chk("bp_req_ready", {31'b0, req_ready}, 32'h0);
            chk("bp_rsp_valid", {31'b0, rsp_valid}, 32'h1);
            chk("bp_rdata_stable", rsp_rdata, held);
            chk("bp_no_setup", {31'b0, psel}, 32'h0);
        end
        $display("txn bp: RD addr=0x21 rdata=0x%08h held 5 cycles", rsp_rdata);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("bp_consumed_valid", {31'b0, rsp_valid}, 32'h0);
        chk("bp_consumed_ready", {31'b0, req_ready}, 32'h1);
        chk("bp_no_overlap_psel", {31'b0, psel}, 32'h0);
        step();
        req_valid = 1'b0;
        chk("bp_next_setup", {30'b0, psel, penable}, 32'h2);
        chk("bp_next_paddr", {25'b0, paddr}, 32'h33);
        step();
        pready = 1'b1;
        step();
        pready = 1'b0;
        chk("bp_next_rsp", {30'b0, rsp_valid, rsp_err}, 32'h2);
        $display("txn bp2: WR addr=0x33 err=%0b", rsp_err);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Reset asserted mid-ACCESS abandons the transfer
        req_valid = 1'b1; req_write = 1'b0; req_addr = 7'h44;
        step();
        req_valid = 1'b0;
        step();
        chk("rst_pre_access", {30'b0, psel, penable}, 32'h3);
        #2 presetn = 1'b0;
        #1;
        chk("rst_async_ctrl", {29'b0, psel, penable, rsp_valid}, 32'h0);
        step();
        pready = 1'b1; prdata = 32'hDDDD_EEEE;
        step();
        presetn = 1'b1;
        pready = 1'b0;
        chk("rst_release_ready", {31'b0, req_ready}, 32'h1);
        step();
        chk("rst_no_response", {29'b0, psel, penable, rsp_valid}, 32'h0);
        chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
        $display("txn rst: RD addr=0x44 abandoned by reset");

        // Stuck slave: timeout abort when enabled, indefinite wait otherwise
        req_valid = 1'b1; req_write = 1'b0; req_addr = 7'h66;
        step();
        req_valid = 1'b0;
        step();
        chk("stuck_access", {30'b0, psel, penable}, 32'h3);
`ifdef APB_MASTER_TIMEOUT_EN
        for (int c = 0; c < 15; c++) begin
            step();
            chk("tmo_still_access", {30'b0, psel, timeout}, 32'h2);
        end
        prdata = 32'h9999_9999;
        step();
        chk("tmo_psel", {30'b0, psel, penable}, 32'h0);
        chk("tmo_pulse", {31'b0, timeout}, 32'h1);
        chk("tmo_rsp", {30'b0, rsp_valid, rsp_err}, 32'h3);
        chk("tmo_rdata", rsp_rdata, 32'h0);
        $display("txn tmo: RD addr=0x66 timeout err=%0b", rsp_err);
        step();
        chk("tmo_pulse_end", {31'b0, timeout}, 32'h0);
        chk("tmo_rsp_held", {30'b0, rsp_valid, rsp_err}, 32'h3);
`else
        for (int c = 0; c < 20; c++) step();
        chk("notmo_psel_held", {29'b0, psel, penable, timeout}, 32'h6);
        chk("notmo_no_rsp", {31'b0, rsp_valid}, 32'h0);
        pready = 1'b1; prdata = 32'h1357_2468;
        step();
        pready = 1'b0;
        chk("notmo_rsp", {30'b0, rsp_valid, rsp_err}, 32'h2);
        chk("notmo_rdata", rsp_rdata, 32'h1357_2468);
        $display("txn stuck: RD addr=0x66 waited 20 cycles rdata=0x%08h", rsp_rdata);
`endif
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("final_req_ready", {31'b0, req_ready}, 32'h1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
